ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 155 +++++++++++++++
 tb/tb_ram_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: assembles a little-endian byte stream into 16-bit words and
// writes them to consecutive RAM addresses, arbitrating the RAM port against
// a CPU that owns it whenever the loader is idle.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, base, len    one-cycle load request; base/len sampled when accepted
//   abort               cancels an active load (ignored in IDLE and DONE)
//   byte_in/byte_valid  byte stream input; byte_ready is the loader's side
//   cpu_addr/din/we     CPU-side RAM request, forwarded only while idle
//   cpu_stall           high while the CPU is locked out of the RAM
//   ram_addr/din/we     RAM port
//   busy, done          status; done pulses once on normal completion
//   sum                 mod-2^16 sum of words written by the current/last load
//   state_dbg           current FSM state encoding, for observation only
//
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready
// are both high. byte_ready depends only on the state, never on byte_valid,
// and byte_valid may be raised or dropped freely by the source.
`timescale 1ns/1ps
module ram_loader #(
  parameter int DW = 16,   // must be 16: a word is exactly two bytes
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          abort,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic          cpu_stall,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] sum,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] idx;
  logic [7:0]    lo_q;
  logic [7:0]    hi_q;
  logic [DW-1:0] word_q;   // last word that went through WR
  logic [DW-1:0] sum_q;
  logic [AW-1:0] idx_next;
  logic [DW-1:0] word_now;

  assign idx_next = idx + AW'(1);
  assign word_now = {hi_q, lo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      len_q  <= '0;
      idx    <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      word_q <= '0;
      sum_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            len_q  <= len;
            idx    <= '0;
            sum_q  <= '0;
            state  <= (len == '0) ? DONE : LO;
          end
        end
        LO: begin
          if (abort) begin
            state <= IDLE;
          end else if (byte_valid) begin
            lo_q  <= byte_in;
            state <= HI;
          end
        end
        HI: begin
          if (abort) begin
            state <= IDLE;
          end else if (byte_valid) begin
            hi_q  <= byte_in;
            state <= WR;
          end
        end
        WR: begin
          // An abort here cancels the write that would happen this cycle,
          // so the word is not counted in sum either.
          if (abort) begin
            state <= IDLE;
          end else begin
            word_q <= word_now;
            sum_q  <= sum_q + word_now;
            idx    <= idx_next;
            state  <= (idx_next == len_q) ? DONE : LO;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port mux: the CPU owns it in IDLE, the loader everywhere else.
  always_comb begin
    ram_addr = base_q + idx;
    ram_din  = word_q;
    ram_we   = 1'b0;
    case (state)
      IDLE: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we;
      end
      WR: begin
        ram_din = word_now;
        ram_we  = ~abort;
      end
      default: begin
      end
    endcase
  end

  assign byte_ready = (state == LO) || (state == HI);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign cpu_stall  = busy;
  assign sum        = sum_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: randomized loads checked against a word-level model.
// The model lists the (address, word) pairs a load must produce and their
// sum; a negedge monitor pops them as RAM writes appear.
`timescale 1ns/1ps
module tb_ram_loader;
  localparam int AW = 13;
  localparam int DW = 16;
  localparam int W  = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] len;
  logic          abort;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_we;
  logic          cpu_stall;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic          busy;
  logic          done;
  logic [DW-1:0] sum;
  logic [2:0]    state_dbg;

  ram_loader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_we(cpu_we), .cpu_stall(cpu_stall), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .busy(busy), .done(done),
    .sum(sum), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [W-1:0]  exp_q[$];   // {addr, word} in write order
  logic [15:0]   words_q[$]; // words for the next load
  logic [7:0]    bytes_q[$]; // byte stream derived from words_q
  logic [W-1:0]  mon_e;
  logic          mon_have;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && busy && ram_we) begin
      mon_have = (exp_q.size() != 0);
      check_eq("wr_expected", mon_have, 1);
      if (mon_have) begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", ram_addr, mon_e[W-1:DW]);
        check_eq("wr_data", ram_din, mon_e[DW-1:0]);
      end
    end
    if (done) done_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic fill_random(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
  endtask

  // Drive bytes_q[0..nb-1]; start/base/len are scrambled meanwhile to show
  // start is ignored while a load is active. Ends at posedge+1 after the
  // last acceptance edge.
  task automatic feed(input int nb, input bit rv);
    int k = 0;
    int cyc = 0;
    bit acc;
    while (k < nb && cyc < 2000) begin
      byte_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_in    = byte_valid ? bytes_q[k] : 8'($urandom);
      start      = 1'($urandom_range(0, 1));
      base       = AW'($urandom);
      len        = AW'($urandom);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;
    check_eq("feed_count", k, nb);
  endtask

  // Issue a load of words_q. ab_after < 0: run to completion. Otherwise
  // abort is raised ab_wait idle cycles after the ab_after-th byte is taken.
  task automatic run_load(input logic [AW-1:0] b, input logic [AW-1:0] n,
                          input bit rv, input int ab_after, input int ab_wait);
    int nw;
    int ws;
    int s = 0;
    int d0;
    int cyc;
    logic [AW-1:0] a;
    nw = int'(n);
    if (ab_after < 0) ws = nw;
    else begin
      // a word is written once its high byte is in and the WR cycle passed
      ws = ab_after / 2;
      if (ab_after > 0 && ab_after % 2 == 0 && ab_wait == 0) ws = ws - 1;
    end
    bytes_q.delete();
    for (int k = 0; k < nw; k++) begin
      bytes_q.push_back(words_q[k][7:0]);
      bytes_q.push_back(words_q[k][15:8]);
      if (k < ws) begin
        a = b + AW'(k);
        exp_q.push_back({a, words_q[k]});
        s += int'(words_q[k]);
      end
    end
    d0 = done_cnt;
    cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = AW'($urandom);
    cpu_din = DW'($urandom);
    base = b; len = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("ld_stall", cpu_stall, 1);
    check_eq("ld_we_blocked", ram_we, 0);
    check_eq("ld_addr0", ram_addr, b);
    if (ab_after < 0) begin
      feed(2 * nw, rv);
      cyc = 0;
      while (busy && cyc < 8) begin
        @(posedge clk); #1;
        cyc++;
      end
      check_eq("ld_idle", busy, 0);
      check_eq("ld_done_pulses", done_cnt - d0, 1);
    end else begin
      feed(ab_after, rv);
      repeat (ab_wait) begin
        @(posedge clk); #1;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_eq("ab_busy", busy, 0);
      check_eq("ab_ready", byte_ready, 0);
      check_eq("ab_no_done", done_cnt - d0, 0);
    end
    check_eq("ld_sum", sum, 32'(s[15:0]));
    check_eq("ld_pending", exp_q.size(), 0);
    cpu_we = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int d0;
  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; abort = 1'b0;
    byte_in = '0; byte_valid = 1'b0;
    cpu_addr = 13'h0AB; cpu_din = 16'hCAFE; cpu_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", byte_ready, 0);
    check_eq("rst_stall", cpu_stall, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_addr_pass", ram_addr, 13'h0AB);
    check_eq("rst_din_pass", ram_din, 16'hCAFE);

    // idle CPU pass-through
    cpu_addr = 13'h5; cpu_din = 16'hBEEF; cpu_we = 1'b1;
    #1;
    check_eq("cpu_we_pass", ram_we, 1);
    check_eq("cpu_addr_pass", ram_addr, 13'h5);
    check_eq("cpu_din_pass", ram_din, 16'hBEEF);
    check_eq("cpu_no_stall", cpu_stall, 0);
    cpu_we = 1'b0;

    // directed load: 34 12 78 56 -> 0x1234@0x10, 0x5678@0x11
    words_q.delete(); words_q.push_back(16'h1234); words_q.push_back(16'h5678);
    run_load(13'h10, 13'd2, 1'b0, -1, 0);
    check_eq("dir_sum", sum, 16'h68AC);

    // same words with random backpressure
    run_load(13'h10, 13'd2, 1'b1, -1, 0);

    // address wrap
    fill_random(2);
    run_load(13'h1FFF, 13'd2, 1'b1, -1, 0);

    // zero length: done right after the accepting edge, no write
    d0 = done_cnt;
    cpu_we = 1'b1;
    base = 13'h33; len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("zl_done", done, 1);
    check_eq("zl_we_blocked", ram_we, 0);
    @(posedge clk); #1;
    check_eq("zl_done_low", done, 0);
    check_eq("zl_idle", busy, 0);
    check_eq("zl_pulses", done_cnt - d0, 1);
    check_eq("zl_sum", sum, 0);
    cpu_we = 1'b0;

    // aborts: in LO after first word, in WR, in HI, in LO right after start
    fill_random(3); run_load(13'h100, 13'd3, 1'b1, 2, 1);
    fill_random(3); run_load(13'h200, 13'd3, 1'b1, 4, 0);
    fill_random(2); run_load(13'h300, 13'd2, 1'b1, 3, 2);
    fill_random(4); run_load(13'h400, 13'd4, 1'b0, 0, 0);

    // reset while in HI of the second word: first word written, then cleared
    fill_random(2);
    bytes_q.delete();
    for (int k = 0; k < 2; k++) begin
      bytes_q.push_back(words_q[k][7:0]);
      bytes_q.push_back(words_q[k][15:8]);
    end
    exp_q.push_back({13'h020, words_q[0]});
    d0 = done_cnt;
    base = 13'h20; len = 13'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    feed(3, 1'b1);
    check_eq("rh_sum_before", sum, 32'(words_q[0]));
    rst = 1'b1; byte_valid = 1'b1; byte_in = bytes_q[3]; abort = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; byte_valid = 1'b0;
    check_eq("rh_busy", busy, 0);
    check_eq("rh_sum", sum, 0);
    check_eq("rh_no_done", done_cnt - d0, 0);
    check_eq("rh_pending", exp_q.size(), 0);
    words_q.delete(); words_q.push_back(16'h1234); words_q.push_back(16'h5678);
    run_load(13'h10, 13'd2, 1'b1, -1, 0);
    check_eq("rh_dir_sum", sum, 16'h68AC);

    // random loads
    for (int i = 0; i < 8; i++) begin
      fill_random($urandom_range(1, 6));
      run_load(AW'($urandom), AW'(words_q.size()), 1'($urandom_range(0, 1)), -1, 0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
